// File: rtl/isa_ram_writer.sv
// Buffers 128-bit instruction beats in a FIFO and serialises each one into four 32-bit RAM writes.
// Optional macro ISA_WR_RANGE_CHECK_EN drops beats whose address exceeds the RAM instead of wrapping.
module isa_ram_writer #(
    parameter int DEPTH  = 16,
    parameter int RAM_AW = 14
) (
    input  logic              clk_cpu,
    input  logic              rstn,
    input  logic              isa_wren_i,
    input  logic [127:0]      isa_data_i,
    input  logic [31:0]       isa_addr_i,
    input  logic              load_start_i,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic              busy_o,
    output logic              overflow_o,
    output logic              range_err_o,
    output logic [31:0]       words_written_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = RAM_AW - 2;
    localparam int EW = AW + 128;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WR   = 1'b1;

    logic [EW-1:0]  mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [0:0]     state;
    logic [1:0]     lane;
    logic [1:0]     next_lane;
    logic [AW-1:0]  sh_addr;
    logic [127:0]   sh_data;
    logic [EW-1:0]  head;
    logic           in_range;
    logic           pop;
    logic           push;
    logic           full_drop;

    // Only the address bits that land inside the RAM are kept in the FIFO.
`ifdef ISA_WR_RANGE_CHECK_EN
    assign in_range = (isa_addr_i[31:AW] == '0);
`else
    logic unused_addr_hi;
    assign in_range       = 1'b1;
    assign unused_addr_hi = ^isa_addr_i[31:AW];
`endif

    assign head      = mem[rd_ptr];
    assign next_lane = lane + 2'd1;
    assign pop       = (count != '0) && ((state == S_IDLE) || (lane == 2'd3));
    assign push      = isa_wren_i && !load_start_i && in_range && ((count != FULL) || pop);
    assign full_drop = isa_wren_i && !load_start_i && in_range && (count == FULL) && !pop;
    assign busy_o    = (count != '0) || (state != S_IDLE);

    always_ff @(posedge clk_cpu) begin
        if (push) mem[wr_ptr] <= {isa_addr_i[AW-1:0], isa_data_i};
    end

    always_ff @(posedge clk_cpu or negedge rstn) begin
        if (!rstn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            state           <= S_IDLE;
            lane            <= 2'd0;
            sh_addr         <= '0;
            sh_data         <= '0;
            ram_we_o        <= 1'b0;
            ram_addr_o      <= '0;
            ram_wdata_o     <= '0;
            overflow_o      <= 1'b0;
            words_written_o <= '0;
        end else if (load_start_i) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            state           <= S_IDLE;
            lane            <= 2'd0;
            ram_we_o        <= 1'b0;
            overflow_o      <= 1'b0;
            words_written_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (full_drop) overflow_o <= 1'b1;

            // Registered outputs always show the lane currently held in 'lane'.
            if (pop) begin
                state           <= S_WR;
                lane            <= 2'd0;
                sh_addr         <= head[EW-1:128];
                sh_data         <= head[127:0];
                ram_we_o        <= 1'b1;
                ram_addr_o      <= {head[EW-1:128], 2'b00};
                ram_wdata_o     <= head[31:0];
                words_written_o <= words_written_o + 32'd1;
            end else if (state == S_WR && lane != 2'd3) begin
                lane            <= next_lane;
                ram_we_o        <= 1'b1;
                ram_addr_o      <= {sh_addr, next_lane};
                ram_wdata_o     <= sh_data[32*next_lane +: 32];
                words_written_o <= words_written_o + 32'd1;
            end else begin
                state    <= S_IDLE;
                ram_we_o <= 1'b0;
            end
        end
    end

`ifdef ISA_WR_RANGE_CHECK_EN
    always_ff @(posedge clk_cpu or negedge rstn) begin
        if (!rstn)                                    range_err_o <= 1'b0;
        else if (load_start_i)                        range_err_o <= 1'b0;
        else if (isa_wren_i && !in_range)             range_err_o <= 1'b1;
    end
`else
    assign range_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_isa_ram_writer.sv
// Randomised and directed bench for isa_ram_writer against a beat-queue reference model.
module tb_isa_ram_writer;

    localparam int DEPTH  = 16;
    localparam int RAM_AW = 14;
`ifdef ISA_WR_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    logic              clk_cpu = 1'b0;
    logic              rstn    = 1'b0;
    logic              isa_wren_i = 1'b0;
    logic [127:0]      isa_data_i = '0;
    logic [31:0]       isa_addr_i = '0;
    logic              load_start_i = 1'b0;
    logic              ram_we_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [31:0]       ram_wdata_o;
    logic              busy_o;
    logic              overflow_o;
    logic              range_err_o;
    logic [31:0]       words_written_o;

    isa_ram_writer #(.DEPTH(DEPTH), .RAM_AW(RAM_AW)) dut (
        .clk_cpu(clk_cpu), .rstn(rstn), .isa_wren_i(isa_wren_i), .isa_data_i(isa_data_i),
        .isa_addr_i(isa_addr_i), .load_start_i(load_start_i), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .busy_o(busy_o),
        .overflow_o(overflow_o), .range_err_o(range_err_o), .words_written_o(words_written_o)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Reference model: queued beats, the beat being written, and words still to emit.
    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
    } beat_t;

    beat_t       q[$];
    beat_t       cur;
    int          rem;
    logic [31:0] m_words;
    logic        m_ovf;
    logic        m_rerr;
    int          vectors;
    int          miscompares;

    task automatic model_reset();
        q.delete();
        rem     = 0;
        m_words = '0;
        m_ovf   = 1'b0;
        m_rerr  = 1'b0;
        cur.addr = '0;
        cur.data = '0;
    endtask

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [127:0] d,
                              input logic ld);
        bit    pop;
        bit    accept;
        beat_t b;
        if (ld) begin
            model_reset();
            return;
        end
        pop    = (q.size() > 0) && (rem <= 1);
        accept = 1'b0;
        if (w) begin
            if (RANGE_CHECK && (a >> (RAM_AW - 2)) != 0) m_rerr = 1'b1;
            else if (q.size() < DEPTH || pop)            accept = 1'b1;
            else                                         m_ovf  = 1'b1;
        end
        if (pop) begin
            cur = q.pop_front();
            rem = 4;
        end else if (rem > 0) begin
            rem = rem - 1;
        end
        if (accept) begin
            b.addr = a;
            b.data = d;
            q.push_back(b);
        end
        if (rem > 0) m_words = m_words + 32'd1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int                ln;
        logic [RAM_AW-1:0] ea;
        logic [31:0]       ed;
        chk("ram_we", ram_we_o, rem > 0);
        chk("busy", busy_o, (q.size() > 0) || (rem > 0));
        chk("words_written", words_written_o, m_words);
        chk("overflow", overflow_o, m_ovf);
        chk("range_err", range_err_o, m_rerr);
        if (rem > 0) begin
            ln = 4 - rem;
            ea = RAM_AW'((cur.addr % (1 << (RAM_AW - 2))) * 4 + ln);
            ed = 32'(cur.data >> (32 * ln));
            chk("ram_addr", ram_addr_o, ea);
            chk("ram_wdata", ram_wdata_o, ed);
        end
    endtask

    // Drive one cycle of inputs (called just after a negedge), then check after the posedge.
    task automatic cycle(input logic w, input logic [31:0] a, input logic [127:0] d,
                         input logic ld);
        isa_wren_i   = w;
        isa_addr_i   = a;
        isa_data_i   = d;
        load_start_i = ld;
        model_edge(w, a, d, ld);
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while (busy_o && budget < 400) begin
            idle(1);
            budget++;
        end
        chk(tag, busy_o, 1'b0);
    endtask

    initial begin
        int          guard;
        logic [127:0] d;
        vectors     = 0;
        miscompares = 0;
        model_reset();

        // Reset state
        #2;
        chk("reset_we", ram_we_o, 1'b0);
        chk("reset_addr", ram_addr_o, '0);
        chk("reset_wdata", ram_wdata_o, '0);
        check_all();
        @(negedge clk_cpu);
        rstn = 1'b1;
        @(negedge clk_cpu);
        check_all();

        // Single beat at addr 5: writes 0x14..0x17 beginning two cycles after wren
        d = 128'h44444444_33333333_22222222_11111111;
        cycle(1'b1, 32'h5, d, 1'b0);
        chk("single_n1_we", ram_we_o, 1'b0);
        idle(1);
        chk("single_first_addr", ram_addr_o, 14'h14);
        chk("single_first_data", ram_wdata_o, 32'h11111111);
        idle(3);
        chk("single_last_addr", ram_addr_o, 14'h17);
        chk("single_last_data", ram_wdata_o, 32'h44444444);
        idle(1);
        chk("single_words", words_written_o, 32'd4);
        drain("single_busy_fall");

        // Upstream pattern: two beats then one idle cycle, six beats in all
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 32'h40 + 32'(2 * k), rnd_data(), 1'b0);
            cycle(1'b1, 32'h41 + 32'(2 * k), rnd_data(), 1'b0);
            idle(1);
        end
        drain("pattern_busy_fall");
        chk("pattern_overflow", overflow_o, 1'b0);
        chk("pattern_words", words_written_o, 32'd28);

        // Back-to-back burst long enough to fill the FIFO and force drops
        for (int k = 0; k < 2 * DEPTH + 8; k++) cycle(1'b1, 32'h100 + 32'(k), rnd_data(), 1'b0);
        chk("burst_overflow", overflow_o, 1'b1);
        drain("burst_busy_fall");

        // load_start during lane 2 with three beats queued
        cycle(1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h200 + 32'(k), rnd_data(), 1'b0);
        guard = 0;
        while (rem != 2 && guard < 20) begin
            idle(1);
            guard++;
        end
        chk("load_lane2_reached", 32'(rem), 32'd2);
        cycle(1'b1, 32'h300, rnd_data(), 1'b1);
        chk("load_we", ram_we_o, 1'b0);
        chk("load_busy", busy_o, 1'b0);
        chk("load_words", words_written_o, 32'd0);
        idle(6);
        cycle(1'b1, 32'h7, rnd_data(), 1'b0);
        drain("load_after_busy_fall");
        chk("load_after_words", words_written_o, 32'd4);

        // Upper address bits: dropped with range check, wrapped without
        cycle(1'b1, 32'h1000, rnd_data(), 1'b0);
        drain("range_hi_busy_fall");
        chk("range_hi_err", range_err_o, RANGE_CHECK);
        cycle(1'b1, 32'hFFF, rnd_data(), 1'b0);
        idle(1);
        chk("range_fff_addr", ram_addr_o, 14'h3FFC);
        drain("range_fff_busy_fall");

        // Reset in the middle of a beat
        cycle(1'b1, 32'h9, rnd_data(), 1'b0);
        idle(2);
        rstn = 1'b0;
        #1;
        model_reset();
        chk("midreset_we", ram_we_o, 1'b0);
        check_all();
        @(negedge clk_cpu);
        rstn = 1'b1;
        idle(2);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            logic        w;
            logic [31:0] a;
            logic        ld;
            w  = ($urandom_range(0, 99) < 45);
            a  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4095));
            ld = ($urandom_range(0, 149) == 0);
            cycle(w, a, rnd_data(), ld);
        end
        drain("random_busy_fall");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
